rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one 8-input resource between 8 requesters, e.g. a shared memory/bus port whose data path is the 8:1 multiplexer.
- Produces a one-hot grant plus a 3-bit index that drives the multiplexer select directly.
- Holds each grant for a full transaction, until the owner signals done or drops its request.
- Sits between the requesting masters and the shared-resource mux.

---
 rtl/rr_arbiter8.sv | 108 ++++++++++
 tb/tb_rr_arbiter8.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter that holds each grant for a whole transaction and drives the mux select.
// Optional hold-time limit is compiled in with `define RR_ARBITER8_TIMEOUT_EN.
module rr_arbiter8 #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic [7:0] i_Req,
    input  logic       i_Done,
    output logic [7:0] o_Grant,
    output logic [2:0] o_Select,
    output logic       o_Busy,
    output logic       o_Timeout
);
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_param_chk
        $error("rr_arbiter8: TIMEOUT_CYCLES must be in 2..256");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] last_q, last_d;
    logic       timeout_q, timeout_d;

    logic [2:0] win, idx;
    logic       win_vld;
    logic       rel_normal, rel_force, release_now, take;

    // Scan last+1 .. last+8 so the previous owner is considered last.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = last_q + 3'(i);
            if (!win_vld && i_Req[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    assign rel_normal  = i_Done | ~i_Req[sel_q];
    assign release_now = (state_q == GRANT) && (rel_normal || rel_force);
    assign take        = win_vld && ((state_q == IDLE) || release_now);

`ifdef RR_ARBITER8_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    assign rel_force = (state_q == GRANT) && !rel_normal
                       && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (take)                  cnt_d = '0;
        else if (state_q == GRANT) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    assign rel_force = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        if (take) begin
            state_d = GRANT;
            grant_d = 8'b1 << win;
            sel_d   = win;
            last_d  = win;
        end else if (release_now) begin
            // Select keeps its value while idle so the mux output stays quiet.
            state_d = IDLE;
            grant_d = '0;
        end
        if (release_now) timeout_d = rel_force;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            last_q    <= 3'd7;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_Grant   = grant_q;
    assign o_Select  = sel_q;
    assign o_Busy    = (state_q == GRANT);
    assign o_Timeout = timeout_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized traffic against an
// integer-level round-robin model. Honors RR_ARBITER8_TIMEOUT_EN with TIMEOUT_CYCLES=4.
module tb_rr_arbiter8;
    localparam int TC = 4;
`ifdef RR_ARBITER8_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       tout;

    int errors = 0;
    int checks = 0;

    // Reference model state: owner -1 means nobody holds the resource.
    int m_owner, m_last, m_sel, m_hold;
    bit m_to;

    rr_arbiter8 #(.TIMEOUT_CYCLES(TC)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Req(req), .i_Done(done),
        .o_Grant(grant), .o_Select(sel), .o_Busy(busy), .o_Timeout(tout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int from);
        for (int i = 1; i <= 8; i++)
            if (r[(from + i) % 8]) return (from + i) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 7; m_sel = 0; m_hold = 0; m_to = 1'b0;
    endtask

    task automatic model_step();
        int  w;
        bit  normal, forced;
        m_to = 1'b0;
        if (m_owner < 0) begin
            w = pick(req, m_last);
            if (w >= 0) begin m_owner = w; m_last = w; m_sel = w; m_hold = 1; end
        end else begin
            normal = done || !req[m_owner];
            forced = TO_EN && !normal && (m_hold == TC);
            if (normal || forced) begin
                m_to = forced;
                w = pick(req, m_owner);
                if (w >= 0) begin m_owner = w; m_last = w; m_sel = w; m_hold = 1; end
                else m_owner = -1;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || tout !== 1'b0) begin
            errors++;
            $display("FAIL reset: grant=%h sel=%0d busy=%b to=%b want 00/0/0/0", grant, sel, busy, tout);
        end
    endtask

    task automatic test_basic();
        do_reset();
        req = 8'h01; tick();
        checks++;
        if (grant !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_grant: grant=%h sel=%0d busy=%b want 01/0/1", grant, sel, busy);
        end
        req = 8'h00; done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: grant=%h sel=%0d busy=%b want 00/0/0", grant, sel, busy);
        end
        tick();
        checks++;
        if (grant !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: grant=%h busy=%b want 00/0", grant, busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 8'hFF; tick();
        for (int n = 0; n <= 8; n++) begin
            checks++;
            if (sel !== 3'(n % 8) || grant !== (8'h01 << (n % 8)) || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_first n=%0d: sel=%0d grant=%h busy=%b want sel=%0d", n, sel, grant, busy, n % 8);
            end
            tick();
            checks++;
            if (sel !== 3'(n % 8) || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_hold n=%0d: sel=%0d busy=%b want sel=%0d busy=1", n, sel, busy, n % 8);
            end
            done = 1'b1; tick(); done = 1'b0;
        end
        req = 8'h00; done = 1'b1; tick(); done = 1'b0;
    endtask

    task automatic test_wrap_and_drop();
        do_reset();
        req = 8'h80; tick();
        checks++;
        if (grant !== 8'h80 || sel !== 3'd7) begin
            errors++;
            $display("FAIL owner7: grant=%h sel=%0d want 80/7", grant, sel);
        end
        req = 8'b0100_0001; done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (grant !== 8'h01 || sel !== 3'd0) begin
            errors++;
            $display("FAIL wrap: grant=%h sel=%0d want 01/0", grant, sel);
        end
        req = 8'h08; done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (grant !== 8'h08 || sel !== 3'd3) begin
            errors++;
            $display("FAIL owner3: grant=%h sel=%0d want 08/3", grant, sel);
        end
        req = 8'h20; tick();
        checks++;
        if (grant !== 8'h20 || sel !== 3'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL req_drop: grant=%h sel=%0d busy=%b want 20/5/1", grant, sel, busy);
        end
        req = 8'h00; tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h10; tick();
        checks++;
        if (grant !== 8'h10) begin
            errors++;
            $display("FAIL pre_reset_grant: grant=%h want 10", grant);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || tout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: grant=%h sel=%0d busy=%b to=%b want 00/0/0/0", grant, sel, busy, tout);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        req = 8'h30; tick();
        checks++;
        if (grant !== 8'h10 || sel !== 3'd4) begin
            errors++;
            $display("FAIL restart: grant=%h sel=%0d want 10/4", grant, sel);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h04; tick();
        req = 8'h06;
`ifdef RR_ARBITER8_TIMEOUT_EN
        for (int c = 2; c <= TC; c++) begin
            tick();
            checks++;
            if (grant !== 8'h04 || tout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold c=%0d: grant=%h to=%b want 04/0", c, grant, tout);
            end
        end
        tick();
        checks++;
        if (grant !== 8'h02 || sel !== 3'd1 || tout !== 1'b1) begin
            errors++;
            $display("FAIL to_fire: grant=%h sel=%0d to=%b want 02/1/1", grant, sel, tout);
        end
        tick();
        checks++;
        if (grant !== 8'h02 || tout !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: grant=%h to=%b want 02/0", grant, tout);
        end
`else
        for (int c = 0; c < 100; c++) begin
            tick();
            checks++;
            if (grant !== 8'h04 || tout !== 1'b0) begin
                errors++;
                $display("FAIL no_to_hold c=%0d: grant=%h to=%b want 04/0", c, grant, tout);
            end
        end
`endif
        req = 8'h00; tick();
    endtask

    task automatic test_random();
        logic [7:0] eg;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            done = ($urandom_range(0, 3) == 0);
            tick();
            eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
            checks++;
            if (grant !== eg || sel !== 3'(m_sel) || busy !== (m_owner >= 0) || tout !== m_to) begin
                errors++;
                $display("FAIL random c=%0d: grant=%h sel=%0d busy=%b to=%b want %h/%0d/%b/%b",
                         c, grant, sel, busy, tout, eg, m_sel, m_owner >= 0, m_to);
            end
            checks++;
            if (busy !== (|grant) || !$onehot0(grant)) begin
                errors++;
                $display("FAIL invariant c=%0d: grant=%h busy=%b", c, grant, busy);
            end
        end
        done = 1'b0; req = 8'h00;
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap_and_drop();
        test_async_reset();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
